vga_draw_arbiter: RTL

//   Shares the single VGA adapter pixel port among NUM_REQ renderers (plate, cakes, eraser, score).

---
 rtl/draw_arb_pkg.sv | 23 ++
 rtl/rr_picker.sv | 36 +++
 rtl/vga_draw_arbiter.sv | 134 +++++++++++++
 3 files changed

// File: rtl/draw_arb_pkg.sv
// rtl/draw_arb_pkg.sv - shared types and helpers for the VGA draw arbiter
// Purpose: arbiter state encoding, default pixel bus widths and the
//          packed-bus slice index helper used by vga_draw_arbiter.
// Ports:   none (package).
package draw_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_DRAW    = 2'd2,
    ST_RELEASE = 2'd3
  } arb_state_t;

  localparam int DEF_X_W = 8;
  localparam int DEF_Y_W = 7;
  localparam int DEF_C_W = 3;

  // Low bit of requester idx's field in a bus packed at idx*width.
  function automatic int slice_lo(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// rtl/rr_picker.sv - combinational round-robin requester picker
// Purpose: returns the first set req bit at or above ptr, wrapping to 0.
// Ports:
//   req    in   NUM_REQ   request vector
//   ptr    in   IDX_W     search start position
//   idx    out  IDX_W     selected requester (0 when none)
//   valid  out  1         1 when any req bit is set
module rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [IDX_W-1:0]   idx,
  output logic               valid
);

  int pos;

  // Scan from the farthest offset down to ptr itself so that the last
  // hit written, the nearest one at or after ptr, is the one that sticks.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    pos   = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      pos = int'(ptr) + k;
      if (pos >= NUM_REQ) pos = pos - NUM_REQ;
      if (req[pos]) begin
        idx   = IDX_W'(pos);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vga_draw_arbiter.sv
// rtl/vga_draw_arbiter.sv - round-robin owner of the VGA adapter pixel port
// Purpose: grants the pixel port to one renderer per burst (round-robin),
//          holds the grant until that renderer's done, and registers the
//          granted renderer's x/y/colour/plot into the adapter.
// Option:  DRAW_ARB_TIMEOUT_EN adds a DRAW-cycle watchdog and timeout_err.
// Ports:
//   clock, resetn                 clock, asynchronous active-low reset
//   req, done      in  NUM_REQ    per-renderer request level / last-pixel flag
//   x_in, y_in, colour_in  in     packed pixel buses, renderer i at [i*W +: W]
//   grant          out NUM_REQ    one-hot owner during GRANT/DRAW, else 0
//   busy           out 1          high outside IDLE
//   x, y, colour, plot  out       registered pixel bus to the adapter
//   timeout_err    out 1          sticky watchdog flag (option only)
module vga_draw_arbiter
  import draw_arb_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int X_W            = DEF_X_W,
  parameter int Y_W            = DEF_Y_W,
  parameter int C_W            = DEF_C_W,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                   clock,
  input  logic                   resetn,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [NUM_REQ-1:0]     done,
  input  logic [NUM_REQ*X_W-1:0] x_in,
  input  logic [NUM_REQ*Y_W-1:0] y_in,
  input  logic [NUM_REQ*C_W-1:0] colour_in,
  output logic [NUM_REQ-1:0]     grant,
  output logic                   busy,
  output logic [X_W-1:0]         x,
  output logic [Y_W-1:0]         y,
  output logic [C_W-1:0]         colour,
  output logic                   plot
`ifdef DRAW_ARB_TIMEOUT_EN
  ,
  output logic                   timeout_err
`endif
);

  localparam int IDX_W = $clog2(NUM_REQ);

  arb_state_t       state, state_nxt;
  logic [IDX_W-1:0] ptr, g, pick_idx;
  logic             pick_valid;
  logic             done_g;

  rr_picker #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_picker (
    .req   (req),
    .ptr   (ptr),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  // Only the owner's done counts; everyone else's is ignored.
  assign done_g = done[g];

`ifdef DRAW_ARB_TIMEOUT_EN
  logic [7:0] draw_cnt;
  logic       tmo_hit;

  // draw_cnt counts DRAW cycles already completed, so TIMEOUT_CYCLES-1 marks
  // the last permitted DRAW cycle.
  assign tmo_hit = (state == ST_DRAW) && !done_g &&
                   (draw_cnt == 8'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      draw_cnt    <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (state == ST_GRANT)     draw_cnt <= '0;
      else if (state == ST_DRAW) draw_cnt <= draw_cnt + 8'd1;
      if (tmo_hit) timeout_err <= 1'b1;
    end
  end
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (pick_valid) state_nxt = ST_GRANT;
      ST_GRANT:   state_nxt = ST_DRAW;
      ST_DRAW: begin
        if (done_g) state_nxt = ST_RELEASE;
`ifdef DRAW_ARB_TIMEOUT_EN
        else if (tmo_hit) state_nxt = ST_RELEASE;
`endif
      end
      ST_RELEASE: state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state <= ST_IDLE;
      ptr   <= '0;
      g     <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE && pick_valid) g <= pick_idx;
      if (state == ST_RELEASE)
        ptr <= (g == IDX_W'(NUM_REQ - 1)) ? '0 : g + IDX_W'(1);
    end
  end

  // Pixel bus only loads while drawing so the adapter sees stable values
  // whenever plot is low.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      x      <= '0;
      y      <= '0;
      colour <= '0;
      plot   <= 1'b0;
    end else begin
      plot <= (state == ST_DRAW);
      if (state == ST_DRAW) begin
        x      <= x_in[slice_lo(int'(g), X_W) +: X_W];
        y      <= y_in[slice_lo(int'(g), Y_W) +: Y_W];
        colour <= colour_in[slice_lo(int'(g), C_W) +: C_W];
      end
    end
  end

  always_comb begin
    grant = '0;
    if (state == ST_GRANT || state == ST_DRAW) grant[g] = 1'b1;
  end

  assign busy = (state != ST_IDLE);

endmodule
